seg7_scan_driver: RTL and testbench

Multiplexed N-digit seven-segment display driver. It latches a packed BCD/hex value, decodes each nibble to segment patterns, and time-multiplexes the digits onto one shared segment bus with per-digit anode enables. It sits between the display-value producers (counters, status registers) and the board's common-anode display pins, and replaces the single-digit combinational decoder for all multi-digit displays.

---
 rtl/seg7_scan_driver_if.sv | 24 ++
 rtl/seg7_scan_driver.sv | 142 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_if.sv
// Display-side bus of the seven-segment scan driver.
// The producer drives value/load/blank; the driver returns the pin levels.
interface seg7_scan_driver_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp;
  logic                  blank;
  logic [6:0]            seg;
  logic                  dp_out;
  logic [DIGITS-1:0]     an;
  logic                  frame_tick;

  modport master (
    output load, value, dp, blank,
    input  seg, dp_out, an, frame_tick
  );

  modport slave (
    input  load, value, dp, blank,
    output seg, dp_out, an, frame_tick
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit seven-segment driver: latches a packed nibble value,
// decodes one digit per dwell period and drives the shared segment bus.
module seg7_scan_driver #(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned CLK_DIV        = 50000,
  parameter bit          HEX_EN         = 1'b1,
  parameter bit          LZ_SUPPRESS    = 1'b1,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  seg7_scan_driver_if.slave  bus
);

  localparam int unsigned VAL_W = 4 * DIGITS;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [6:0]        SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7f : 7'h00;
  localparam logic              DP_OFF   = SEG_ACTIVE_LOW;
  localparam logic [DIGITS-1:0] AN_OFF   = AN_ACTIVE_LOW ? '1 : '0;

  // Active-low segment pattern {a..g}; codes 10..15 go dark without hex.
  function automatic logic [6:0] decode_al(input logic [3:0] code);
    logic [6:0] pat;
    pat = 7'h7f;
    case (code)
      4'h0: pat = 7'b0000001;
      4'h1: pat = 7'b1001111;
      4'h2: pat = 7'b0010010;
      4'h3: pat = 7'b0000110;
      4'h4: pat = 7'b1001100;
      4'h5: pat = 7'b0100100;
      4'h6: pat = 7'b0100000;
      4'h7: pat = 7'b0001111;
      4'h8: pat = 7'b0000000;
      4'h9: pat = 7'b0000100;
      4'ha: pat = HEX_EN ? 7'b0001000 : 7'h7f;
      4'hb: pat = HEX_EN ? 7'b1100000 : 7'h7f;
      4'hc: pat = HEX_EN ? 7'b0110001 : 7'h7f;
      4'hd: pat = HEX_EN ? 7'b1000010 : 7'h7f;
      4'he: pat = HEX_EN ? 7'b0110000 : 7'h7f;
      4'hf: pat = HEX_EN ? 7'b0111000 : 7'h7f;
      default: pat = 7'h7f;
    endcase
    return pat;
  endfunction

  logic [CNT_W-1:0]  presc_q, presc_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              wrap_q, wrap_d;
  logic [VAL_W-1:0]  val_q, val_d;
  logic [DIGITS-1:0] dp_q, dp_d;

  logic [IDX_W+1:0]  shamt;
  logic [3:0]        nib;
  logic              lz_hit;
  logic [6:0]        seg_al;
  logic              dp_lit;
  logic [DIGITS-1:0] an_hot;
  logic [6:0]        seg_d;
  logic              dp_out_d;
  logic [DIGITS-1:0] an_d;
  logic              tick_d;

  // Next scan state plus the output image of the digit currently selected.
  always_comb begin
    presc_d  = presc_q;
    idx_d    = idx_q;
    wrap_d   = 1'b0;
    val_d    = val_q;
    dp_d     = dp_q;
    shamt    = {idx_q, 2'b00};
    nib      = val_q[shamt +: 4];
    lz_hit   = 1'b0;
    seg_al   = 7'h7f;
    dp_lit   = 1'b0;
    an_hot   = '0;
    seg_d    = SEG_OFF;
    dp_out_d = DP_OFF;
    an_d     = AN_OFF;
    tick_d   = wrap_q;

    if (presc_q == CNT_LAST) begin
      presc_d = '0;
      wrap_d  = (idx_q == IDX_LAST);
      idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end else begin
      presc_d = presc_q + CNT_W'(1);
    end

    if (bus.load) begin
      val_d = bus.value;
      dp_d  = bus.dp;
    end

    // A digit is a leading zero when it and everything above it is zero.
    lz_hit = LZ_SUPPRESS && (idx_q != '0) && ((val_q >> shamt) == '0);
    seg_al = lz_hit ? 7'h7f : decode_al(nib);
    dp_lit = dp_q[idx_q];
    an_hot = DIGITS'(1) << idx_q;

    if (bus.blank) begin
      seg_al = 7'h7f;
      dp_lit = 1'b0;
      an_hot = '0;
    end

    seg_d    = SEG_ACTIVE_LOW ? seg_al : ~seg_al;
    dp_out_d = SEG_ACTIVE_LOW ? ~dp_lit : dp_lit;
    an_d     = AN_ACTIVE_LOW ? ~an_hot : an_hot;
  end

  // State and registered pin drivers.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q        <= '0;
      idx_q          <= '0;
      wrap_q         <= 1'b0;
      val_q          <= '0;
      dp_q           <= '0;
      bus.seg        <= SEG_OFF;
      bus.dp_out     <= DP_OFF;
      bus.an         <= AN_OFF;
      bus.frame_tick <= 1'b0;
    end else begin
      presc_q        <= presc_d;
      idx_q          <= idx_d;
      wrap_q         <= wrap_d;
      val_q          <= val_d;
      dp_q           <= dp_d;
      bus.seg        <= seg_d;
      bus.dp_out     <= dp_out_d;
      bus.an         <= an_d;
      bus.frame_tick <= tick_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: a hex-enabled and a hex-disabled instance share
// stimulus and are compared each cycle against a time-based display model.
module tb_seg7_scan_driver;

  localparam int unsigned DIGITS  = 4;
  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned FRAME   = DIGITS * CLK_DIV;

  localparam logic [6:0] PAT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg7_scan_driver_if #(.DIGITS(DIGITS)) bus ();
  seg7_scan_driver_if #(.DIGITS(DIGITS)) bus_nh ();

  assign bus_nh.load  = bus.load;
  assign bus_nh.value = bus.value;
  assign bus_nh.dp    = bus.dp;
  assign bus_nh.blank = bus.blank;

  seg7_scan_driver #(
    .DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .HEX_EN(1'b1), .LZ_SUPPRESS(1'b1),
    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  seg7_scan_driver #(
    .DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .HEX_EN(1'b0), .LZ_SUPPRESS(1'b1),
    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut_nh (.clk(clk), .rst(rst), .bus(bus_nh));

  int checks = 0;
  int errors = 0;

  // Model: shadow contents and number of running edges since reset release.
  logic [15:0] m_val = '0;
  logic [3:0]  m_dp  = '0;
  int          m_k   = 0;
  logic [12:0] e_hex, e_nh;

  function automatic int shown_digit();
    return (m_k / CLK_DIV) % DIGITS;
  endfunction

  // Expected {seg, dp_out, an, frame_tick} after the coming edge.
  function automatic logic [12:0] exp_out(input bit hex_en);
    logic [6:0] s;
    logic [3:0] a;
    logic       d_o;
    logic       t;
    logic [3:0] nib;
    int         d;
    if (rst) return {7'h7f, 1'b1, 4'hf, 1'b0};
    d   = shown_digit();
    nib = 4'(m_val >> (4 * d));
    t   = (m_k > 0) && (m_k % FRAME == 0);
    if (bus.blank) begin
      s = 7'h7f; a = 4'hf; d_o = 1'b1;
    end else begin
      if (d != 0 && (m_val >> (4 * d)) == 16'h0) s = 7'h7f;
      else if (!hex_en && nib > 4'd9)            s = 7'h7f;
      else                                       s = PAT[nib];
      a   = ~(4'b0001 << d);
      d_o = ~m_dp[d];
    end
    return {s, d_o, a, t};
  endfunction

  // One clock: freeze expectations, take the edge, advance the model.
  task automatic step();
    e_hex = exp_out(1'b1);
    e_nh  = exp_out(1'b0);
    @(posedge clk);
    if (rst) begin
      m_k = 0; m_val = '0; m_dp = '0;
    end else begin
      m_k = m_k + 1;
      if (bus.load) begin m_val = bus.value; m_dp = bus.dp; end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.load = 1'b0; bus.value = '0; bus.dp = '0; bus.blank = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.an !== 4'b1111 || bus.seg !== 7'b1111111 || bus.frame_tick !== 1'b0 || bus.dp_out !== 1'b1) begin
        errors++;
        $display("FAIL reset_hold an=%b seg=%b tick=%b dp=%b required an=1111 seg=1111111 tick=0 dp=1",
                 bus.an, bus.seg, bus.frame_tick, bus.dp_out);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({bus.seg, bus.dp_out, bus.an, bus.frame_tick} !== e_hex) begin
        errors++;
        $display("FAIL release cyc=%0d got %b required %b", i, {bus.seg, bus.dp_out, bus.an, bus.frame_tick}, e_hex);
      end
    end
    checks++;
    if (bus.an !== 4'b1101) begin
      errors++;
      $display("FAIL release_advance an=%b required 1101", bus.an);
    end
  endtask

  task automatic test_scan();
    int ticks = 0;
    bus.value = 16'h12AF; bus.dp = 4'b0000; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      ticks += int'(bus.frame_tick);
      checks++;
      if ({bus.seg, bus.dp_out, bus.an, bus.frame_tick} !== e_hex) begin
        errors++;
        $display("FAIL scan cyc=%0d got %b required %b", i, {bus.seg, bus.dp_out, bus.an, bus.frame_tick}, e_hex);
      end
    end
    checks++;
    if (ticks != 2) begin
      errors++;
      $display("FAIL frame_tick_count got %0d required 2", ticks);
    end
  endtask

  task automatic test_hex_off_lz();
    logic [15:0] vals [2] = '{16'h00B5, 16'h0000};
    for (int v = 0; v < 2; v++) begin
      bus.value = vals[v]; bus.load = 1'b1;
      step();
      bus.load = 1'b0;
      for (int i = 0; i < FRAME; i++) begin
        step();
        checks++;
        if ({bus_nh.seg, bus_nh.dp_out, bus_nh.an, bus_nh.frame_tick} !== e_nh) begin
          errors++;
          $display("FAIL hex_off_lz val=%h got %b required %b", vals[v],
                   {bus_nh.seg, bus_nh.dp_out, bus_nh.an, bus_nh.frame_tick}, e_nh);
        end
      end
    end
  endtask

  task automatic test_dp_blank();
    bus.value = 16'h4321; bus.dp = 4'b0100; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    for (int i = 0; i < FRAME + 10 + 2 * FRAME; i++) begin
      bus.blank = (i >= 5 && i < 15);
      step();
      checks++;
      if ({bus.seg, bus.dp_out, bus.an, bus.frame_tick} !== e_hex ||
          (bus.an != 4'b1111 && bus.dp_out !== (bus.an != 4'b1011))) begin
        errors++;
        $display("FAIL dp_blank cyc=%0d got %b required %b", i, {bus.seg, bus.dp_out, bus.an, bus.frame_tick}, e_hex);
      end
    end
    bus.blank = 1'b0;
  endtask

  task automatic test_back_to_back();
    int guard = 0;
    bus.dp = 4'b0000;
    while ((m_k % CLK_DIV) != CLK_DIV - 1 && guard < 2 * CLK_DIV) begin
      step(); guard++;
    end
    checks++;
    if ((m_k % CLK_DIV) != CLK_DIV - 1) begin
      errors++;
      $display("FAIL align_budget k=%0d required phase %0d", m_k, CLK_DIV - 1);
    end
    bus.value = 16'h9999; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    step();
    checks++;
    if (bus.seg !== 7'b0000100 || bus.an !== ~(4'b0001 << shown_digit_prev())) begin
      errors++;
      $display("FAIL load_advance seg=%b an=%b required seg=0000100 an=%b",
               bus.seg, bus.an, ~(4'b0001 << shown_digit_prev()));
    end
  endtask

  // Digit displayed by the most recent edge.
  function automatic int shown_digit_prev();
    return ((m_k - 1) / CLK_DIV) % DIGITS;
  endfunction

  task automatic test_mid_reset();
    int guard = 0;
    while (shown_digit_prev() != 2 && guard < 2 * FRAME) begin
      step(); guard++;
    end
    bus.value = 16'h8888; bus.load = 1'b1; rst = 1'b1;
    step();
    checks++;
    if (bus.an !== 4'b1111 || bus.seg !== 7'h7f || {bus.seg, bus.dp_out, bus.an, bus.frame_tick} !== e_hex) begin
      errors++;
      $display("FAIL mid_reset got %b required %b", {bus.seg, bus.dp_out, bus.an, bus.frame_tick}, e_hex);
    end
    bus.load = 1'b0; rst = 1'b0;
    for (int i = 0; i < FRAME + 1; i++) begin
      step();
      checks++;
      if ({bus.seg, bus.dp_out, bus.an, bus.frame_tick} !== e_hex ||
          (i == 0 && (bus.an !== 4'b1110 || bus.seg !== 7'b0000001))) begin
        errors++;
        $display("FAIL restart cyc=%0d got %b required %b", i, {bus.seg, bus.dp_out, bus.an, bus.frame_tick}, e_hex);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.load  = ($urandom_range(0, 4) == 0);
      bus.value = 16'($urandom);
      if ($urandom_range(0, 1) == 0) bus.value[15:8] = 8'h00;
      bus.dp    = 4'($urandom);
      bus.blank = ($urandom_range(0, 9) == 0);
      step();
      checks++;
      if ({bus.seg, bus.dp_out, bus.an, bus.frame_tick} !== e_hex ||
          {bus_nh.seg, bus_nh.dp_out, bus_nh.an, bus_nh.frame_tick} !== e_nh) begin
        errors++;
        $display("FAIL random cyc=%0d got %b/%b required %b/%b", i,
                 {bus.seg, bus.dp_out, bus.an, bus.frame_tick},
                 {bus_nh.seg, bus_nh.dp_out, bus_nh.an, bus_nh.frame_tick}, e_hex, e_nh);
      end
    end
    bus.load = 1'b0; bus.blank = 1'b0;
  endtask

  initial begin
    bus.load = 1'b0; bus.value = '0; bus.dp = '0; bus.blank = 1'b0;
    test_reset();
    test_scan();
    test_hex_off_lz();
    test_dp_blank();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
